// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO result registers.
// Arithmetic ops hold busy for a fixed cycle count; mthi/mtlo write at the accepting edge.
module mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [2:0]         op_r, op_s;
  logic [WIDTH-1:0]   a_r, a_s;
  logic [WIDTH-1:0]   b_r, b_s;
  logic [WIDTH-1:0]   hi_r, hi_s;
  logic [WIDTH-1:0]   lo_r, lo_s;
  logic               busy_r, done_r, done_s;
  logic [2*WIDTH-1:0] mul_s, div_s;
  logic               is_div_s;

  // Full-width product; sign-extending to 2*WIDTH makes an unsigned multiply give the signed result.
  function automatic logic [2*WIDTH-1:0] mul_full(input logic sgn,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
    logic [2*WIDTH-1:0] xe;
    logic [2*WIDTH-1:0] ye;
    xe = sgn ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
    ye = sgn ? {{WIDTH{y[WIDTH-1]}}, y} : {{WIDTH{1'b0}}, y};
    return xe * ye;
  endfunction

  // Returns {remainder, quotient}. Magnitude division avoids signed overflow, so
  // most-negative / -1 naturally yields quotient = dividend, remainder = 0.
  function automatic logic [2*WIDTH-1:0] div_full(input logic sgn,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
    logic             neg_x;
    logic             neg_y;
    logic [WIDTH-1:0] mag_x;
    logic [WIDTH-1:0] mag_y;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    neg_x = sgn & x[WIDTH-1];
    neg_y = sgn & y[WIDTH-1];
    mag_x = neg_x ? -x : x;
    mag_y = neg_y ? -y : y;
    if (mag_y == {WIDTH{1'b0}}) begin
      q = {WIDTH{1'b0}};
      r = {WIDTH{1'b0}};
    end else begin
      q = mag_x / mag_y;
      r = mag_x % mag_y;
    end
    return {(neg_x ? -r : r), ((neg_x ^ neg_y) ? -q : q)};
  endfunction

  assign mul_s    = mul_full(op_r == OP_MULT, a_r, b_r);
  assign div_s    = div_full(op_r == OP_DIV, a_r, b_r);
  assign is_div_s = (op_r == OP_DIV) || (op_r == OP_DIVU);

  // Next-state, operand capture and HI/LO update.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    op_s    = op_r;
    a_s     = a_r;
    b_s     = b_r;
    hi_s    = hi_r;
    lo_s    = lo_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              state_s = RUN;
              cnt_s   = CNT_W'(MULT_CYCLES);
              op_s    = op;
              a_s     = a;
              b_s     = b;
            end
            OP_DIV, OP_DIVU: begin
              state_s = RUN;
              cnt_s   = CNT_W'(DIV_CYCLES);
              op_s    = op;
              a_s     = a;
              b_s     = b;
            end
            OP_MTHI: hi_s = a;
            OP_MTLO: lo_s = a;
            default: state_s = IDLE;
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r <= CNT_W'(1'b1)) begin
          state_s = IDLE;
          cnt_s   = {CNT_W{1'b0}};
          done_s  = 1'b1;
          if (!is_div_s) begin
            {hi_s, lo_s} = mul_s;
          end else if (b_r != {WIDTH{1'b0}}) begin
            {hi_s, lo_s} = div_s;
          end else begin
            // Divide by zero: the op still completes but the result registers are kept.
            hi_s = hi_r;
            lo_s = lo_r;
          end
        end else begin
          cnt_s = cnt_r - CNT_W'(1'b1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and output registers; reset wins over any acceptance or completion.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      op_r    <= 3'd0;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      op_r    <= op_s;
      a_r     <= a_s;
      b_r     <= b_s;
      hi_r    <= hi_s;
      lo_r    <= lo_s;
      busy_r  <= (state_s == RUN);
      done_r  <= done_s;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL provide parameter WIDTH, default 32: operand and HI/LO width in bits, minimum 8.
REQ-002 SHALL provide parameter MULT_CYCLES, default 5: busy cycles for mult/multu, minimum 1.
REQ-003 SHALL provide parameter DIV_CYCLES, default 10: busy cycles for div/divu, minimum 1.
REQ-004 SHALL provide port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL provide port reset  input  1  synchronous, active-low reset (0 = reset), sampled on the clk rising edge.
REQ-006 SHALL provide port start  input  1  operation request, qualified by busy=0.
REQ-007 SHALL provide port op  input  3  operation code: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6-7 reserved.
REQ-008 SHALL provide port a  input  WIDTH  first operand (multiplicand/dividend/move source).
REQ-009 SHALL provide port b  input  WIDTH  second operand (multiplier/divisor).
REQ-010 SHALL provide port busy  output  1  high while an arithmetic operation is in flight.
REQ-011 SHALL provide port done  output  1  one-cycle pulse when HI/LO take an arithmetic result.
REQ-012 SHALL provide ports hi and lo  output  WIDTH  current HI and LO register contents.

Function
REQ-013 SHALL implement a two-state FSM, IDLE and RUN, with a down-counter cnt sized for max(MULT_CYCLES, DIV_CYCLES).
REQ-014 SHALL accept a request only in IDLE with start=1; start with busy=1 SHALL be ignored entirely, including mthi/mtlo.
REQ-015 SHALL, on accepting op 0-3 at edge k, latch a, b and op, enter RUN, load cnt with the op's cycle count, and drive busy=1 for cycles k+1 through k+N, N being MULT_CYCLES or DIV_CYCLES.
REQ-016 SHALL decrement cnt each RUN cycle; at the edge where cnt reaches 0 (edge k+N), it SHALL write HI/LO, return to IDLE, and assert done for exactly the following cycle.
REQ-017 SHALL make a new request acceptable in the cycle after busy falls, so back-to-back ops are N+1 edges apart.
REQ-018 SHALL, for mult, form the 2*WIDTH-bit two's-complement product: HI = upper WIDTH bits, LO = lower WIDTH bits; multu SHALL do the same with unsigned operands.
REQ-019 SHALL, for div, set LO to the quotient truncated toward zero and HI to the remainder carrying the dividend's sign; divu SHALL do the same with unsigned operands.
REQ-020 SHALL, for div with a = most-negative value and b = -1, set LO = a and HI = 0.
REQ-021 SHALL, for div/divu with b = 0, still run DIV_CYCLES busy cycles and pulse done, but leave HI and LO unchanged.
REQ-022 SHALL, for mthi/mtlo accepted in IDLE, write a to HI or LO at that edge with no busy cycle and no done pulse.
REQ-023 SHALL treat reserved op 6-7 with start=1 as a no-op: no state change, busy stays 0.
REQ-024 SHALL ensure hi/lo change only at a REQ-016 or REQ-022 edge and never show intermediate values.
REQ-025 SHALL make results independent of a/b changes after the accepting edge.

Reset
REQ-026 SHALL, with reset=0 at a rising edge, set state=IDLE, cnt=0, hi=0, lo=0, busy=0, done=0, regardless of start.
REQ-027 SHALL, with reset mid-RUN, discard the in-flight operation with no HI/LO write and no done pulse.
REQ-028 SHALL let reset take priority over a simultaneous completion or acceptance.

Verification
REQ-029 SHALL cover: WIDTH=32, mult a=0xFFFFFFFE (-2), b=3 -> busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done one cycle.
REQ-030 SHALL cover: multu a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
REQ-031 SHALL cover: div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles; then div a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
REQ-032 SHALL cover: mthi a=0x1234 then divu a=5, b=0 -> hi=0x1234 retained, lo unchanged, 10 busy cycles, done pulses.
REQ-033 SHALL cover: mtlo with start=1 during busy -> ignored, lo keeps its prior value; reset=0 in the 3rd RUN cycle -> hi=lo=0, busy=0, no done.
REQ-034 SHALL cover: WIDTH=16, MULT_CYCLES=1 -> mult a=0x8000, b=0x8000 gives hi=0x4000, lo=0x0000 with busy high exactly 1 cycle.
